// File: rtl/multiport_regfile_pkg.sv
`default_nettype none
// ============================================================================
// multiport_regfile_pkg : shared defaults and helpers for the register file
// Rev 1.0
// ============================================================================
package multiport_regfile_pkg;

  localparam int c_def_width      = 32;
  localparam int c_def_addr_width = 5;
  localparam int c_def_ports      = 2;
  localparam int c_zero_addr      = 0;

  // Index of the first register that needs real storage.
  function automatic int first_cell(input bit zero_reg);
    return zero_reg ? 1 : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multiport_regfile_if.sv
`default_nettype none
// ============================================================================
// multiport_regfile_if : decode/writeback bus into the multiport register file
// Rev 1.0
// ============================================================================
interface multiport_regfile_if
  import multiport_regfile_pkg::*;
#(
  parameter int WIDTH      = c_def_width,
  parameter int ADDR_WIDTH = c_def_addr_width,
  parameter int NUM_READ   = c_def_ports,
  parameter int NUM_WRITE  = c_def_ports
);

  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr;
  logic [NUM_READ*WIDTH-1:0]       rd_data;
  logic [NUM_READ-1:0]             rd_busy;
  logic [NUM_WRITE-1:0]            wr_en;
  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WRITE*WIDTH-1:0]      wr_data;
  logic                            issue_en;
  logic [ADDR_WIDTH-1:0]           issue_addr;
  logic                            flush;
  logic [ADDR_WIDTH:0]             busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
    output rd_data, rd_busy, busy_count
  );

endinterface
`default_nettype wire

// File: rtl/multiport_regfile_cell.sv
`default_nettype none
// ============================================================================
// multiport_regfile_cell : one WIDTH-bit register with enable, async clear
// Rev 1.0
// ============================================================================
module multiport_regfile_cell #(
  parameter int WIDTH = 32
) (
  input  wire logic             clock,
  input  wire logic             clear,
  input  wire logic             en,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/multiport_regfile.sv
`default_nettype none
// ============================================================================
// multiport_regfile : N-read/M-write register file with bypass and busy scoreboard
// Rev 1.0
// ============================================================================
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int WIDTH      = c_def_width,
  parameter int ADDR_WIDTH = c_def_addr_width,
  parameter int NUM_READ   = c_def_ports,
  parameter int NUM_WRITE  = c_def_ports,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input wire logic           clock,
  input wire logic           clear,
  multiport_regfile_if.slave bus
);

  localparam int                    c_depth = 1 << ADDR_WIDTH;
  localparam int                    c_first = first_cell(ZERO_REG != 0);
  localparam logic [ADDR_WIDTH-1:0] c_zero  = ADDR_WIDTH'(c_zero_addr);

  logic [WIDTH-1:0]      w_q  [c_depth];
  logic [WIDTH-1:0]      w_wd [c_depth];
  logic [c_depth-1:0]    w_we;
  logic [c_depth-1:0]    r_busy;
  logic [c_depth-1:0]    w_busy_nxt;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic [ADDR_WIDTH-1:0] w_ra;
  logic                  w_byp;

  // Per-register priority select: later (higher-index) ports override earlier ones.
  always_comb begin
    w_we = '0;
    for (int r = 0; r < c_depth; r++) begin
      w_wd[r] = '0;
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (r >= c_first && bus.wr_en[w] &&
            bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
          w_we[r] = 1'b1;
          w_wd[r] = bus.wr_data[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar r = 0; r < c_depth; r++) begin : g_reg
    if (r < c_first) begin : g_zero
      assign w_q[r] = '0;
    end else begin : g_cell
      multiport_regfile_cell #(.WIDTH(WIDTH)) u_cell (
        .clock (clock),
        .clear (clear),
        .en    (w_we[r]),
        .d     (w_wd[r]),
        .q     (w_q[r])
      );
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    w_ra        = '0;
    w_byp       = 1'b0;
    for (int p = 0; p < NUM_READ; p++) begin
      w_ra  = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      w_byp = (BYPASS != 0) && w_we[w_ra];
      bus.rd_data[p*WIDTH +: WIDTH] = w_byp ? w_wd[w_ra] : w_q[w_ra];
      bus.rd_busy[p]                = r_busy[w_ra] & ~w_byp;
    end
  end

  // Flush, then writeback clear, then issue set: a new producer always wins.
  always_comb begin
    w_busy_nxt = bus.flush ? '0 : (r_busy & ~w_we);
    if (bus.issue_en && !(ZERO_REG != 0 && bus.issue_addr == c_zero)) begin
      w_busy_nxt[bus.issue_addr] = 1'b1;
    end
    w_count_nxt = '0;
    for (int r = 0; r < c_depth; r++) begin
      w_count_nxt = w_count_nxt + (ADDR_WIDTH+1)'(w_busy_nxt[r]);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign bus.busy_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multiport_regfile.sv
`default_nettype none
// ============================================================================
// tb_multiport_regfile : directed and random checks against a reference model
// Rev 1.0
// ============================================================================
module tb_multiport_regfile;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int D  = 1 << AW;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  logic [W-1:0] m_mem  [D];
  bit           m_busy [D];
  int           m_count;

  always #5 clock = ~clock;

  multiport_regfile_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW)) bus ();

  multiport_regfile #(
    .WIDTH(W), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < D; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
    m_count = 0;
  endtask

  function automatic logic [W-1:0] exp_data(input logic [AW-1:0] a);
    logic [W-1:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
    for (int w = 0; w < NW; w++)
      if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == a) v = bus.wr_data[w*W +: W];
    return v;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    for (int w = 0; w < NW; w++)
      if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_update();
    logic [AW-1:0] a;
    if (bus.flush)
      for (int r = 0; r < D; r++) m_busy[r] = 1'b0;
    for (int w = 0; w < NW; w++) begin
      a = bus.wr_addr[w*AW +: AW];
      if (bus.wr_en[w] && a != 0) begin
        m_mem[a]  = bus.wr_data[w*W +: W];
        m_busy[a] = 1'b0;
      end
    end
    if (bus.issue_en && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1'b1;
    m_count = 0;
    for (int r = 0; r < D; r++) m_count += int'(m_busy[r]);
  endtask

  task automatic idle();
    bus.rd_addr    = '0;
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;
    bus.flush      = 1'b0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic sample();
    logic [AW-1:0] a;
    #1;
    for (int p = 0; p < NR; p++) begin
      a = bus.rd_addr[p*AW +: AW];
      check_eq($sformatf("rd_data%0d@%0d", p, a), 64'(bus.rd_data[p*W +: W]), 64'(exp_data(a)));
      check_eq($sformatf("rd_busy%0d@%0d", p, a), 64'(bus.rd_busy[p]), 64'(exp_busy(a)));
    end
    check_eq("busy_count", 64'(bus.busy_count), 64'(m_count));
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  initial begin
    idle();
    model_reset();
    repeat (3) @(negedge clock);
    clear = 1'b1;

    // Reset state across all addresses
    for (int a = 0; a < D; a++) begin
      idle();
      bus.rd_addr = {AW'(D - 1 - a), AW'(a)};
      sample();
      check_eq("reset_rd0", 64'(bus.rd_data[W-1:0]), 64'd0);
      advance();
    end

    // Same-cycle bypass of a fresh write
    idle();
    bus.wr_en = 2'b01; bus.wr_addr[AW-1:0] = AW'(5); bus.wr_data[W-1:0] = 32'hDEADBEEF;
    bus.rd_addr = {AW'(5), AW'(5)};
    sample();
    check_eq("bypass_5", 64'(bus.rd_data[W-1:0]), 64'hDEADBEEF);
    advance();

    // Two ports hitting one address: port 1 wins
    idle();
    bus.wr_en   = 2'b11;
    bus.wr_addr = {AW'(7), AW'(7)};
    bus.wr_data = {32'h22, 32'h11};
    bus.rd_addr = {AW'(5), AW'(7)};
    sample();
    check_eq("multi_bypass_7", 64'(bus.rd_data[W-1:0]), 64'h22);
    advance();
    idle();
    bus.rd_addr = {AW'(5), AW'(7)};
    sample();
    check_eq("multi_stored_7", 64'(bus.rd_data[W-1:0]), 64'h22);
    check_eq("stored_5", 64'(bus.rd_data[2*W-1:W]), 64'hDEADBEEF);
    advance();

    // Register zero stays zero and never busy
    idle();
    bus.wr_en = 2'b01; bus.wr_data[W-1:0] = 32'hFFFF_FFFF;
    bus.issue_en = 1'b1; bus.issue_addr = '0;
    sample();
    check_eq("zero_bypass", 64'(bus.rd_data[W-1:0]), 64'd0);
    check_eq("zero_busy", 64'(bus.rd_busy[0]), 64'd0);
    advance();
    idle();
    sample();
    check_eq("zero_count", 64'(bus.busy_count), 64'd0);
    advance();

    // Scoreboard sequence
    idle(); bus.issue_en = 1'b1; bus.issue_addr = AW'(3);
    sample(); advance();
    idle(); bus.issue_en = 1'b1; bus.issue_addr = AW'(4);
    sample();
    check_eq("sb_count1", 64'(bus.busy_count), 64'd1);
    advance();
    idle(); bus.issue_en = 1'b1; bus.issue_addr = AW'(3);
    bus.wr_en = 2'b01; bus.wr_addr[AW-1:0] = AW'(3); bus.wr_data[W-1:0] = 32'h33;
    sample();
    check_eq("sb_count2", 64'(bus.busy_count), 64'd2);
    advance();
    idle(); bus.flush = 1'b1; bus.issue_en = 1'b1; bus.issue_addr = AW'(9);
    bus.rd_addr = {AW'(3), AW'(9)};
    sample();
    check_eq("sb_wb_issue_busy3", 64'(bus.rd_busy[1]), 64'd1);
    check_eq("sb_count_pre_flush", 64'(bus.busy_count), 64'd2);
    advance();
    idle(); bus.rd_addr = {AW'(3), AW'(9)};
    sample();
    check_eq("sb_flush_count", 64'(bus.busy_count), 64'd1);
    check_eq("sb_flush_busy9", 64'(bus.rd_busy[0]), 64'd1);
    check_eq("sb_flush_busy3", 64'(bus.rd_busy[1]), 64'd0);
    advance();

    // Asynchronous clear in the middle of a cycle
    idle();
    bus.wr_en = 2'b01; bus.wr_addr[AW-1:0] = AW'(10); bus.wr_data[W-1:0] = 32'h55;
    bus.issue_en = 1'b1; bus.issue_addr = AW'(12);
    sample(); advance();
    idle(); bus.rd_addr = {AW'(12), AW'(10)};
    sample();
    check_eq("pre_clear_10", 64'(bus.rd_data[W-1:0]), 64'h55);
    #1 clear = 1'b0;
    #1;
    model_reset();
    check_eq("clear_data10", 64'(bus.rd_data[W-1:0]), 64'd0);
    check_eq("clear_busy12", 64'(bus.rd_busy[1]), 64'd0);
    check_eq("clear_count", 64'(bus.busy_count), 64'd0);
    bus.wr_en = 2'b01; bus.wr_addr[AW-1:0] = AW'(10); bus.wr_data[W-1:0] = 32'h77;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    idle(); bus.rd_addr = {AW'(12), AW'(10)};
    sample();
    check_eq("lost_write10", 64'(bus.rd_data[W-1:0]), 64'd0);
    advance();

    // Randomized traffic with address collisions encouraged
    for (int i = 0; i < 400; i++) begin
      idle();
      for (int w = 0; w < NW; w++) begin
        bus.wr_en[w] = 1'($urandom % 2);
        bus.wr_addr[w*AW +: AW] = ($urandom % 4 == 0) ? AW'($urandom_range(0, 3))
                                                      : AW'($urandom_range(0, D - 1));
        bus.wr_data[w*W +: W] = W'($urandom);
      end
      for (int p = 0; p < NR; p++) begin
        if ($urandom % 2 == 1)
          bus.rd_addr[p*AW +: AW] = bus.wr_addr[($urandom % NW)*AW +: AW];
        else
          bus.rd_addr[p*AW +: AW] = AW'($urandom_range(0, D - 1));
      end
      bus.issue_en   = 1'($urandom % 3 != 0);
      bus.issue_addr = AW'($urandom_range(0, D - 1));
      bus.flush      = ($urandom % 25 == 0);
      sample();
      advance();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
